// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for one shared AES cipher core.
// Optional RUN watchdog abort is enabled by defining AES_ARB_WDOG_EN.
module aes_req_arbiter #(
  parameter int WDOG_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req0_text,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_text,
  input  logic [127:0] req1_key,
  output logic [1:0]   rsp_valid,
  output logic [127:0] rsp_text,
  output logic         core_ld,
  output logic [127:0] core_text,
  output logic [127:0] core_key,
  input  logic         core_done,
  input  logic [127:0] core_text_out,
  output logic         busy,
  output logic         wdog_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  state_t     state;
  logic       last;
  logic       owner;
  logic [1:0] grant;

  if (WDOG_CYCLES < 16 || WDOG_CYCLES > 255) begin : g_bad_wdog
    $error("WDOG_CYCLES must lie in 16..255");
  end

  // last == 1 means requester 1 was served most recently
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !rst) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign busy      = (state != IDLE);

`ifdef AES_ARB_WDOG_EN
  localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYCLES - 1);

  logic [7:0] wdog_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_text  <= '0;
      core_ld   <= 1'b0;
      core_text <= '0;
      core_key  <= '0;
      wdog_cnt  <= '0;
      wdog_err  <= 1'b0;
    end else begin
      core_ld   <= 1'b0;
      rsp_valid <= 2'b00;
      wdog_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|grant) begin
            owner     <= grant[1];
            core_text <= grant[1] ? req1_text : req0_text;
            core_key  <= grant[1] ? req1_key : req0_key;
            core_ld   <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          wdog_cnt <= '0;
          state    <= RUN;
        end
        RUN: begin
          // a completion in the expiry cycle still delivers real data
          if (core_done) begin
            rsp_text  <= core_text_out;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end else if (wdog_cnt == WDOG_LIM) begin
            rsp_text  <= '0;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            wdog_err  <= 1'b1;
            state     <= RESP;
          end else begin
            wdog_cnt <= wdog_cnt + 8'd1;
          end
        end
        RESP: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign wdog_err = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_text  <= '0;
      core_ld   <= 1'b0;
      core_text <= '0;
      core_key  <= '0;
    end else begin
      core_ld   <= 1'b0;
      rsp_valid <= 2'b00;
      unique case (state)
        IDLE: begin
          if (|grant) begin
            owner     <= grant[1];
            core_text <= grant[1] ? req1_text : req0_text;
            core_key  <= grant[1] ? req1_key : req0_key;
            core_ld   <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (core_done) begin
            rsp_text  <= core_text_out;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end
        end
        RESP: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter; the watchdog case follows AES_ARB_WDOG_EN.
module tb_aes_req_arbiter;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req0_text;
  logic [127:0] req0_key;
  logic [127:0] req1_text;
  logic [127:0] req1_key;
  logic [1:0]   rsp_valid;
  logic [127:0] rsp_text;
  logic         core_ld;
  logic [127:0] core_text;
  logic [127:0] core_key;
  logic         core_done;
  logic [127:0] core_text_out;
  logic         busy;
  logic         wdog_err;

  int tests;
  int fails;

  aes_req_arbiter #(.WDOG_CYCLES(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req0_text     (req0_text),
    .req0_key      (req0_key),
    .req1_text     (req1_text),
    .req1_key      (req1_key),
    .rsp_valid     (rsp_valid),
    .rsp_text      (rsp_text),
    .core_ld       (core_ld),
    .core_text     (core_text),
    .core_key      (core_key),
    .core_done     (core_done),
    .core_text_out (core_text_out),
    .busy          (busy),
    .wdog_err      (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TXT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY1 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] TXT1 = 128'h0f0e0d0c0b0a09080706050403020100;

  logic       exp_own;
  logic [1:0] exp_oh;

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    req_valid     = 2'b11;
    req0_text     = TXT0;
    req0_key      = KEY0;
    req1_text     = TXT1;
    req1_key      = KEY1;
    core_done     = 1'b0;
    core_text_out = '0;

    // reset held two cycles with both requests pending
    step();
    step();
    chk("rst_req_ready", 128'(req_ready), 128'(2'b00));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(2'b00));
    chk("rst_rsp_text", rsp_text, '0);
    chk("rst_core_ld", 128'(core_ld), 128'(1'b0));
    chk("rst_core_text", core_text, '0);
    chk("rst_core_key", core_key, '0);
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_wdog_err", 128'(wdog_err), 128'(1'b0));

    // single request from requester 0
    rst       = 1'b0;
    req_valid = 2'b01;
    #1;
    chk("single_ready", 128'(req_ready), 128'(2'b01));
    step();
    req_valid = 2'b00;
    #1;
    chk("single_ld", 128'(core_ld), 128'(1'b1));
    chk("single_core_text", core_text, TXT0);
    chk("single_core_key", core_key, KEY0);
    chk("single_ready_load", 128'(req_ready), 128'(2'b00));
    chk("single_busy", 128'(busy), 128'(1'b1));
    step();
    chk("single_ld_drop", 128'(core_ld), 128'(1'b0));
    step();
    step();
    core_done     = 1'b1;
    core_text_out = CT0;
    step();
    core_done = 1'b0;
    chk("single_rsp_valid", 128'(rsp_valid), 128'(2'b01));
    chk("single_rsp_text", rsp_text, CT0);
    step();
    chk("single_rsp_drop", 128'(rsp_valid), 128'(2'b00));
    chk("single_idle", 128'(busy), 128'(1'b0));
    chk("single_core_hold", core_text, TXT0);

    // contention from a fresh reset: grants go 0,1,0,1
    rst = 1'b1;
    step();
    rst       = 1'b0;
    req_valid = 2'b11;
    exp_own   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_oh = exp_own ? 2'b10 : 2'b01;
      #1;
      chk($sformatf("cont%0d_ready", i), 128'(req_ready), 128'(exp_oh));
      step();
      chk($sformatf("cont%0d_text", i), core_text, exp_own ? TXT1 : TXT0);
      chk($sformatf("cont%0d_key", i), core_key, exp_own ? KEY1 : KEY0);
      step();
      core_done     = 1'b1;
      core_text_out = 128'hc0de_0000 + 128'(i);
      step();
      core_done = 1'b0;
      chk($sformatf("cont%0d_rsp", i), 128'(rsp_valid), 128'(exp_oh));
      chk($sformatf("cont%0d_rsp_text", i), rsp_text, 128'hc0de_0000 + 128'(i));
      step();
      exp_own = ~exp_own;
    end

    // abort: reset during RUN, then a stray core_done in IDLE
    req_valid = 2'b01;
    #1;
    step();
    req_valid = 2'b00;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'(1'b0));
    chk("abort_rsp", 128'(rsp_valid), 128'(2'b00));
    core_done     = 1'b1;
    core_text_out = 128'hdead_beef;
    step();
    core_done = 1'b0;
    chk("stray_done_busy", 128'(busy), 128'(1'b0));
    chk("stray_done_rsp", 128'(rsp_valid), 128'(2'b00));
    chk("stray_done_text", rsp_text, '0);
    step();
    chk("stray_done_rsp2", 128'(rsp_valid), 128'(2'b00));

    // requester 1 served normally after the abort
    req_valid = 2'b10;
    #1;
    chk("post_abort_ready", 128'(req_ready), 128'(2'b10));
    step();
    req_valid = 2'b00;
    chk("post_abort_text", core_text, TXT1);
    chk("post_abort_ld", 128'(core_ld), 128'(1'b1));
    step();
    core_done     = 1'b1;
    core_text_out = 128'h1234;
    step();
    core_done = 1'b0;
    chk("post_abort_rsp", 128'(rsp_valid), 128'(2'b10));
    chk("post_abort_rsp_text", rsp_text, 128'h1234);
    step();

    // core_done withheld in RUN
    req_valid = 2'b01;
    #1;
    step();
    req_valid = 2'b00;
    step();
`ifdef AES_ARB_WDOG_EN
    for (int c = 1; c < 32; c++) step();
    chk("wdog_early_err", 128'(wdog_err), 128'(1'b0));
    chk("wdog_early_rsp", 128'(rsp_valid), 128'(2'b00));
    step();
    chk("wdog_err", 128'(wdog_err), 128'(1'b1));
    chk("wdog_rsp", 128'(rsp_valid), 128'(2'b01));
    chk("wdog_rsp_text", rsp_text, '0);
    step();
    chk("wdog_err_drop", 128'(wdog_err), 128'(1'b0));
    chk("wdog_idle", 128'(busy), 128'(1'b0));
`else
    for (int c = 0; c < 100; c++) step();
    chk("nowdog_busy", 128'(busy), 128'(1'b1));
    chk("nowdog_rsp", 128'(rsp_valid), 128'(2'b00));
    chk("nowdog_err", 128'(wdog_err), 128'(1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter: WDOG_CYCLES, 32, maximum cycles in RUN without core_done before watchdog abort (range 16..255).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester request (bit i = requester i); held until accepted.
REQ-005 req_ready  out  2  accept strobe; request i accepted in the cycle req_valid[i] && req_ready[i].
REQ-006 req0_text  in  128  requester 0 plaintext; sampled on accept.
REQ-007 req0_key  in  128  requester 0 key; sampled on accept.
REQ-008 req1_text  in  128  requester 1 plaintext; sampled on accept.
REQ-009 req1_key  in  128  requester 1 key; sampled on accept.
REQ-010 rsp_valid  out  2  one-cycle result strobe to owning requester.
REQ-011 rsp_text  out  128  result data; valid only while rsp_valid != 0.
REQ-012 core_ld  out  1  load strobe to the shared cipher core.
REQ-013 core_text  out  128  plaintext to core; registered.
REQ-014 core_key  out  128  key to core; registered.
REQ-015 core_done  in  1  core completion pulse.
REQ-016 core_text_out  in  128  core ciphertext; valid with core_done.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 wdog_err  out  1  one-cycle watchdog abort strobe.

Function
REQ-019 States SHALL be IDLE, LOAD, RUN, RESP; arbiter serves exactly one request at a time.
REQ-020 IDLE: req_ready SHALL be one-hot on the winner among asserted req_valid bits, else 0; acceptance captures text/key/owner and moves to LOAD.
REQ-021 Arbitration SHALL be round-robin: when both valid, the requester not last granted wins; single valid requester always wins.
REQ-022 LOAD: core_ld SHALL be 1 for exactly one cycle with captured core_text/core_key; next state RUN.
REQ-023 RUN: on core_done, core_text_out SHALL be captured into rsp_text; next state RESP.
REQ-024 RESP: rsp_valid[owner] SHALL be 1 for exactly one cycle; last-grant updates to owner; next state IDLE.
REQ-025 Latency: accept at cycle T, core_ld at T+1, rsp_valid one cycle after core_done is sampled.
REQ-026 core_done outside RUN SHALL be ignored (no state, output or data change).
REQ-027 req_ready SHALL be 0 in LOAD, RUN and RESP; new requests wait, nothing is queued.
REQ-028 core_text/core_key SHALL hold their values from LOAD until the next acceptance.

Reset
REQ-029 rst SHALL force IDLE; req_ready, rsp_valid, rsp_text, core_ld, core_text, core_key, busy, wdog_err SHALL be 0.
REQ-030 Last-grant SHALL reset to requester 1, so requester 0 wins the first contention.
REQ-031 rst mid-operation SHALL abandon the request with no rsp_valid; rst has priority over all events in the same cycle.

Configuration
REQ-032 Macro AES_ARB_WDOG_EN defined: a counter SHALL clear on entering RUN and increment each RUN cycle; if it reaches WDOG_CYCLES without core_done, the next cycle SHALL pulse wdog_err and rsp_valid[owner] with rsp_text = 0, update last-grant and return to IDLE; core_done in the same cycle as expiry wins.
REQ-033 Macro undefined: no counter exists, RUN waits indefinitely, wdog_err tied 0, WDOG_CYCLES unused.

Verification
REQ-034 Reset: assert rst 2 cycles with req_valid=11 -> all outputs 0, busy 0.
REQ-035 Single request: req_valid=01, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff -> req_ready=01 one cycle, core_ld next cycle, then rsp_valid=01 with rsp_text 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-036 Contention: req_valid=11 held for four transactions -> grant order 0,1,0,1; each rsp_valid matches its owner.
REQ-037 Abort: rst pulsed in RUN, then core_done pulsed in IDLE -> no rsp_valid, no state change; next req1 request served normally.
REQ-038 Watchdog (AES_ARB_WDOG_EN, WDOG_CYCLES=32): core_done withheld -> wdog_err and rsp_valid pulse at cycle 33 of RUN with rsp_text 0; without macro, busy stays 1 for 100 cycles.
